outagu_nd: RTL
==============

// Module: outagu_nd
// PURPOSE
//  Strided N-level output address generator for the MVU quantizer write-back path into local data memory.
//  Replaces the single-counter base+1 scheme with NLOOPS nested loop counters, each with its own length and jump stride.
//  One address is emitted per accepted step. Reports busy, last and done to the MVU controller.
// PARAMETERS
//  BDBANKA  15  data-memory address width
//  NLOOPS   3   number of nested loop levels, 1..8; level 0 is innermost
//  BCNT     8   width of each loop length field
// PORTS
//  clk       in   1               system clock, all logic on posedge
//  rst       in   1               asynchronous, active-high reset
//  load      in   1               latch config, restart sequence at baseaddr
//  step      in   1               advance to next address (quantizer wrote one word)
//  baseaddr  in   BDBANKA         start address
//  lengths   in   NLOOPS*BCNT     per-level iteration count; field k = bits [k*BCNT +: BCNT]
//  strides   in   NLOOPS*BDBANKA  per-level jump added when level k is the lowest level not rolling over
//  addrout   out  BDBANKA         current write address (registered)
//  busy      out  1               in RUN state
//  last      out  1               addrout is the final address of the sequence
//  done      out  1               sequence exhausted; held until next load
//  ringend   in   BDBANKA         only with OUTAGU_ND_WRAP_EN: exclusive ring upper bound
// BEHAVIOUR
//  Reset (async): addrout=0, all counters=0, state=IDLE, busy=0, last=0, done=0.
//  Config (lengths, strides, ringend) is sampled only on load. Later input changes have no effect until the next load.
//  A length of 0 is treated as 1.
//  States:
//   IDLE --load--> RUN
//   RUN  --step on last address--> DONE
//   DONE --load--> RUN
//   RUN  --load--> RUN (restart)
//  load: next cycle addrout=baseaddr, counters=0, state=RUN, done=0. Latency 1 cycle.
//  step in RUN, not last: find the lowest k with cnt[k] != len[k]-1.
//   Set cnt[j]=0 for all j<k, then cnt[k]++, addrout += strides[k].
//   Latency 1 cycle. A step is accepted on every cycle it is high.
//  step in RUN with last=1: state=DONE, done=1, busy=0. addrout holds the final value.
//  step in IDLE or DONE: ignored, no state or output change.
//  load and step in the same cycle: load wins and the step is dropped.
//  last (comb from regs) = busy & all cnt[k]==len[k]-1.
//  Sequence length = product of lengths. All are 1 -> last=1 right after load.
//  Arithmetic: addrout + stride is computed modulo 2^BDBANKA.
//   Strides are two's complement, so negative jumps are legal. Address wrap at 2^BDBANKA is silent.
//  Reset mid-sequence: immediate return to IDLE with the reset values above.
//   A load is required before further steps are honoured.
// CONFIGURATION
//  OUTAGU_ND_WRAP_EN defined:
//   Adds port ringend and ring-buffer addressing over [baseaddr, ringend).
//   Strides are treated as unsigned and must be < ringend-baseaddr.
//   nxt = addrout + stride, computed at BDBANKA+1 bits.
//   If nxt >= ringend: addrout <= nxt - (ringend - baseaddr).
//   ringend <= baseaddr disables wrapping.
//  OUTAGU_ND_WRAP_EN undefined:
//   No ringend port, no compare or subtract logic; plain modulo-2^BDBANKA addition only.
// STRUCTURE
//  Package outagu_pkg holds:
//   state encoding constants OAGU_IDLE=2'd0, OAGU_RUN=2'd1, OAGU_DONE=2'd2;
//   default widths OAGU_BDBANKA=15, OAGU_BCNT=8;
//   NLOOPS_MAX=8.
//  Sub-module outagu_lvl: one loop level (cnt register, wrap flag, clear/inc controls), generated NLOOPS times.
//  Top level holds the FSM, priority-encoded stride select, the address adder and the optional wrap logic.
// TESTING
//  1. NLOOPS=3; base=100; lengths=(2,3,4) for L0,L1,L2; strides L0=1, L1=7, L2=-20; load then 24 steps.
//     -> addresses follow the nested pattern 100,101,108,109,116,117,97,...
//     -> last=1 on the 24th address; done=1 after the 24th step; busy=0.
//  2. Mid-run, issue load and step in the same cycle with base=500.
//     -> addrout=500 next cycle; counters=0; step dropped.
//  3. All lengths=1 or 0; load.
//     -> last=1 immediately; one step -> done=1; further steps leave addrout unchanged.
//  4. Assert rst asynchronously between clock edges mid-sequence.
//     -> outputs 0 with no clock edge; steps ignored until load.
//  5. Base=0x7FFE, L0 stride=1, length 4.
//     -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
//  6. With OUTAGU_ND_WRAP_EN: base=16, ringend=20, L0 stride=3, length 5.
//     -> addresses 16, 19, 18, 17, 16.

Source files
------------

// File: rtl/outagu_nd_pkg.sv
// Shared constants for the strided N-level output address generator (outagu_nd).
// State encodings, default widths and the loop-depth ceiling.
package outagu_pkg;
  localparam logic [1:0] OAGU_IDLE    = 2'd0;
  localparam logic [1:0] OAGU_RUN     = 2'd1;
  localparam logic [1:0] OAGU_DONE    = 2'd2;
  localparam int         OAGU_BDBANKA = 15;
  localparam int         OAGU_BCNT    = 8;
  localparam int         NLOOPS_MAX   = 8;
endpackage

// File: rtl/outagu_nd_lvl.sv
// One loop level of outagu_nd: iteration counter plus latched length.
// o_wrap flags that this level sits on its final iteration.
module outagu_lvl
  import outagu_pkg::*;
#(
  parameter int BCNT = OAGU_BCNT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic [BCNT-1:0] i_len,
  input  logic            i_clr,
  input  logic            i_inc,
  output logic            o_wrap
);
  localparam logic [BCNT-1:0] ONE = BCNT'(1);

  logic [BCNT-1:0] r_len;
  logic [BCNT-1:0] r_cnt;
  logic [BCNT-1:0] w_len_eff;

  // Length is configuration only; it needs no reset because busy gates its use.
  always_ff @(posedge clk) begin
    if (i_load) r_len <= i_len;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + ONE;
  end

  // A zero length behaves as a single iteration.
  assign w_len_eff = (r_len == '0) ? ONE : r_len;
  assign o_wrap    = (r_cnt == (w_len_eff - ONE));
endmodule

// File: rtl/outagu_nd.sv
// Strided N-level output address generator for quantizer write-back.
// Optional ring-buffer addressing is enabled by defining OUTAGU_ND_WRAP_EN.
module outagu_nd
  import outagu_pkg::*;
#(
  parameter int BDBANKA = OAGU_BDBANKA,
  parameter int NLOOPS  = 3,
  parameter int BCNT    = OAGU_BCNT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      step,
  input  logic [BDBANKA-1:0]        baseaddr,
  input  logic [NLOOPS*BCNT-1:0]    lengths,
  input  logic [NLOOPS*BDBANKA-1:0] strides,
  output logic [BDBANKA-1:0]        addrout,
  output logic                      busy,
  output logic                      last,
`ifdef OUTAGU_ND_WRAP_EN
  output logic                      done,
  input  logic [BDBANKA-1:0]        ringend
`else
  output logic                      done
`endif
);
  logic [1:0]                r_state;
  logic [BDBANKA-1:0]        r_addr;
  logic [NLOOPS*BDBANKA-1:0] r_strides;
  logic [NLOOPS-1:0]         w_wrap;
  logic [NLOOPS-1:0]         w_clr;
  logic [NLOOPS-1:0]         w_inc;
  logic [BDBANKA-1:0]        w_stride;
  logic [BDBANKA-1:0]        w_nxt;
  logic                      w_busy;
  logic                      w_last;
  logic                      w_adv;
  logic                      w_found;

  assign w_busy = (r_state == OAGU_RUN);
  assign w_last = w_busy & (&w_wrap);
  assign w_adv  = step & w_busy & ~load & ~w_last;

  always_ff @(posedge clk) begin
    if (load) r_strides <= strides;
  end

  for (genvar k = 0; k < NLOOPS; k++) begin : g_lvl
    outagu_lvl #(.BCNT(BCNT)) u_lvl (
      .clk    (clk),
      .rst    (rst),
      .i_load (load),
      .i_len  (lengths[k*BCNT +: BCNT]),
      .i_clr  (w_clr[k] | load),
      .i_inc  (w_inc[k]),
      .o_wrap (w_wrap[k])
    );
  end

  // Lowest level not on its last iteration takes the increment; all below it restart.
  always_comb begin
    w_clr    = '0;
    w_inc    = '0;
    w_stride = '0;
    w_found  = 1'b0;
    for (int k = 0; k < NLOOPS; k++) begin
      if (!w_found) begin
        if (!w_wrap[k]) begin
          w_found  = 1'b1;
          w_inc[k] = w_adv;
          w_stride = r_strides[k*BDBANKA +: BDBANKA];
        end else begin
          w_clr[k] = w_adv;
        end
      end
    end
  end

`ifdef OUTAGU_ND_WRAP_EN
  logic [BDBANKA-1:0] r_base;
  logic [BDBANKA-1:0] r_ringend;

  always_ff @(posedge clk) begin
    if (load) begin
      r_base    <= baseaddr;
      r_ringend <= ringend;
    end
  end

  // Sum kept one bit wider so crossing the ring end is detected before truncation.
  function automatic logic [BDBANKA-1:0] f_ring(input logic [BDBANKA-1:0] a,
                                                input logic [BDBANKA-1:0] s,
                                                input logic [BDBANKA-1:0] b,
                                                input logic [BDBANKA-1:0] e);
    logic [BDBANKA:0] sum;
    logic [BDBANKA:0] dif;
    sum = {1'b0, a} + {1'b0, s};
    dif = sum - {1'b0, e - b};
    if ((e > b) && (sum >= {1'b0, e})) f_ring = dif[BDBANKA-1:0];
    else                               f_ring = sum[BDBANKA-1:0];
  endfunction

  assign w_nxt = f_ring(r_addr, w_stride, r_base, r_ringend);
`else
  assign w_nxt = r_addr + w_stride;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= OAGU_IDLE;
      r_addr  <= '0;
    end else if (load) begin
      r_state <= OAGU_RUN;
      r_addr  <= baseaddr;
    end else if (w_busy && step) begin
      if (w_last) r_state <= OAGU_DONE;
      else        r_addr  <= w_nxt;
    end
  end

  assign addrout = r_addr;
  assign busy    = w_busy;
  assign last    = w_last;
  assign done    = (r_state == OAGU_DONE);
endmodule
